// File: rtl/karatsuba64_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : karatsuba64_seq_if
// Brief   : Request/result bus and sub-multiplier port of karatsuba64_seq.
// Rev     : 1.0  initial release
// ============================================================================
interface karatsuba64_seq_if;
    logic         start;
    logic [63:0]  A;
    logic [63:0]  B;
    logic         busy;
    logic [127:0] P;
    logic         err;
    logic         valid_out;
    logic         sm_start;
    logic [33:0]  sm_a;
    logic [33:0]  sm_b;
    logic [67:0]  sm_p;
    logic         sm_valid;

    modport master (
        output start, A, B, sm_p, sm_valid,
        input  busy, P, err, valid_out, sm_start, sm_a, sm_b
    );

    modport slave (
        input  start, A, B, sm_p, sm_valid,
        output busy, P, err, valid_out, sm_start, sm_a, sm_b
    );
endinterface
`default_nettype wire

// File: rtl/karatsuba64_seq.sv
`default_nettype none
// ============================================================================
// Module  : karatsuba64_seq
// Brief   : Sequential 64x64 Karatsuba multiplier over one shared 34x34 port.
// Rev     : 1.0  initial release
// ============================================================================
module karatsuba64_seq #(
    parameter int TIMEOUT = 1023
) (
    input  wire logic         clk,
    input  wire logic         rst,
    karatsuba64_seq_if.slave  bus
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE0  = 3'd1;
    localparam logic [2:0] WAIT0   = 3'd2;
    localparam logic [2:0] ISSUE1  = 3'd3;
    localparam logic [2:0] WAIT1   = 3'd4;
    localparam logic [2:0] ISSUE2  = 3'd5;
    localparam logic [2:0] WAIT2   = 3'd6;
    localparam logic [2:0] COMBINE = 3'd7;

    localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW:0]   TIMEOUT_V = (CW + 1)'(TIMEOUT);

    logic [2:0]    r_state;
    logic [63:0]   r_a;
    logic [63:0]   r_b;
    logic [67:0]   r_z0;
    logic [67:0]   r_z1;
    logic [67:0]   r_z2;
    logic [127:0]  r_p;
    logic          r_valid;
    logic          r_err;
    logic [33:0]   r_sm_a;
    logic [33:0]   r_sm_b;
    logic [CW-1:0] r_wd;

    logic [32:0]   w_a_sum;
    logic [32:0]   w_b_sum;
    logic [67:0]   w_mid;
    logic [127:0]  w_prod;
    logic          w_timeout;

    assign w_a_sum = {1'b0, r_a[63:32]} + {1'b0, r_a[31:0]};
    assign w_b_sum = {1'b0, r_b[63:32]} + {1'b0, r_b[31:0]};

    // mid is the true cross term a_hi*b_lo + a_lo*b_hi, never negative
    assign w_mid  = r_z2 - r_z1 - r_z0;
    assign w_prod = ({60'd0, r_z1} << 64) + ({60'd0, w_mid} << 32) + {60'd0, r_z0};

    assign w_timeout = (TIMEOUT != 0) && (({1'b0, r_wd} + (CW + 1)'(1)) == TIMEOUT_V);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_z0    <= '0;
            r_z1    <= '0;
            r_z2    <= '0;
            r_p     <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_sm_a  <= '0;
            r_sm_b  <= '0;
            r_wd    <= '0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_sm_a  <= {2'b00, bus.A[31:0]};
                        r_sm_b  <= {2'b00, bus.B[31:0]};
                        r_state <= ISSUE0;
                    end
                end
                ISSUE0: begin
                    r_wd    <= '0;
                    r_state <= WAIT0;
                end
                ISSUE1: begin
                    r_wd    <= '0;
                    r_state <= WAIT1;
                end
                ISSUE2: begin
                    r_wd    <= '0;
                    r_state <= WAIT2;
                end
                WAIT0, WAIT1, WAIT2: begin
                    if (bus.sm_valid) begin
                        case (r_state)
                            WAIT0: begin
                                r_z0    <= bus.sm_p;
                                r_sm_a  <= {2'b00, r_a[63:32]};
                                r_sm_b  <= {2'b00, r_b[63:32]};
                                r_state <= ISSUE1;
                            end
                            WAIT1: begin
                                r_z1    <= bus.sm_p;
                                r_sm_a  <= {1'b0, w_a_sum};
                                r_sm_b  <= {1'b0, w_b_sum};
                                r_state <= ISSUE2;
                            end
                            default: begin
                                r_z2    <= bus.sm_p;
                                r_state <= COMBINE;
                            end
                        endcase
                    end else if (w_timeout) begin
                        r_p     <= '0;
                        r_err   <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_wd <= r_wd + CW'(1);
                    end
                end
                COMBINE: begin
                    r_p     <= w_prod;
                    r_valid <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // sm_start decodes the ISSUE states, so it is one cycle per product by construction
    assign bus.sm_start  = (r_state == ISSUE0) || (r_state == ISSUE1) || (r_state == ISSUE2);
    assign bus.busy      = (r_state != IDLE);
    assign bus.P         = r_p;
    assign bus.err       = r_err;
    assign bus.valid_out = r_valid;
    assign bus.sm_a      = r_sm_a;
    assign bus.sm_b      = r_sm_b;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba64_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_karatsuba64_seq
// Brief   : Directed self-checking bench for karatsuba64_seq.
// Rev     : 1.0  initial release
// ============================================================================
module tb_karatsuba64_seq;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    karatsuba64_seq_if bus ();
    karatsuba64_seq_if bus_t ();

    karatsuba64_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    karatsuba64_seq #(.TIMEOUT(8)) dut_t (
        .clk (clk),
        .rst (rst),
        .bus (bus_t.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural sub-multipliers with per-product latency (in WAIT cycles)
    int          lat[3];
    int          idx = 0;
    int          n_starts = 0;
    int          cnt = 0;
    bit          pend = 0;
    logic [33:0] ra, rb;
    logic [33:0] cap_a[3];
    logic [33:0] cap_b[3];

    int          lat_t[3];
    int          idx_t = 0;
    int          n_starts_t = 0;
    int          cnt_t = 0;
    bit          pend_t = 0;
    logic [33:0] ra_t, rb_t;

    always @(negedge clk) begin
        bus.sm_valid = 1'b0;
        if (bus.sm_start === 1'b1) begin
            ra = bus.sm_a;
            rb = bus.sm_b;
            cap_a[idx] = bus.sm_a;
            cap_b[idx] = bus.sm_b;
            cnt = lat[idx];
            pend = 1;
            n_starts++;
            idx = (idx + 1) % 3;
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                bus.sm_valid = 1'b1;
                bus.sm_p = {34'd0, ra} * {34'd0, rb};
                pend = 0;
            end
        end
    end

    always @(negedge clk) begin
        bus_t.sm_valid = 1'b0;
        if (bus_t.sm_start === 1'b1) begin
            ra_t = bus_t.sm_a;
            rb_t = bus_t.sm_b;
            cnt_t = lat_t[idx_t];
            pend_t = 1;
            n_starts_t++;
            idx_t = (idx_t + 1) % 3;
        end else if (pend_t) begin
            cnt_t--;
            if (cnt_t == 0) begin
                bus_t.sm_valid = 1'b1;
                bus_t.sm_p = {34'd0, ra_t} * {34'd0, rb_t};
                pend_t = 0;
            end
        end
    end

    task automatic run_op(input bit tsel, input logic [63:0] a, input logic [63:0] b,
                          output logic [127:0] p, output logic e, output int latency,
                          output bit seen);
        int e0;
        seen = 0;
        latency = 0;
        p = '0;
        e = 1'b0;
        @(negedge clk);
        if (tsel) begin
            bus_t.A = a; bus_t.B = b; bus_t.start = 1'b1;
        end else begin
            bus.A = a; bus.B = b; bus.start = 1'b1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus_t.start = 1'b0;
        e0 = cyc;
        for (int i = 0; i < 200; i++) begin
            if ((tsel ? bus_t.valid_out : bus.valid_out) === 1'b1) begin
                seen = 1;
                latency = cyc - e0;
                p = tsel ? bus_t.P : bus.P;
                e = tsel ? bus_t.err : bus.err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({bus.busy, bus.valid_out, bus.err, bus.sm_start, bus.sm_a, bus.sm_b, bus.P} !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got busy=%b vo=%b err=%b sms=%b sma=%h smb=%h P=%h, want all 0",
                     bus.busy, bus.valid_out, bus.err, bus.sm_start, bus.sm_a, bus.sm_b, bus.P);
        end
        n_vec++;
        if ({bus_t.busy, bus_t.valid_out, bus_t.err, bus_t.sm_start, bus_t.P} !== '0) begin
            n_err++;
            $display("FAIL reset_outs_t: got busy=%b vo=%b err=%b P=%h, want all 0",
                     bus_t.busy, bus_t.valid_out, bus_t.err, bus_t.P);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [127:0] p; logic e; int l; bit s;
        lat = '{1, 1, 1}; idx = 0; n_starts = 0;
        run_op(0, 64'd3, 64'd5, p, e, l, s);
        n_vec++;
        if (!s) begin n_err++; $display("FAIL basic_done: valid_out never seen, want pulse"); end
        n_vec++;
        if (l != 7) begin n_err++; $display("FAIL basic_latency: got %0d, want 7", l); end
        n_vec++;
        if (p !== 128'd15) begin n_err++; $display("FAIL basic_p: got %h, want %h", p, 128'd15); end
        n_vec++;
        if (e !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b, want 0", e); end
        n_vec++;
        if (n_starts != 3) begin n_err++; $display("FAIL basic_starts: got %0d, want 3", n_starts); end
        @(negedge clk);
        n_vec++;
        if (bus.valid_out !== 1'b0) begin n_err++; $display("FAIL basic_pulse: valid_out got %b, want 0", bus.valid_out); end
        n_vec++;
        if (bus.P !== 128'd15) begin n_err++; $display("FAIL basic_hold: P got %h, want %h", bus.P, 128'd15); end
    endtask

    task automatic test_all_ones;
        logic [127:0] p; logic e; int l; bit s;
        lat = '{1, 1, 1}; idx = 0; n_starts = 0;
        run_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, p, e, l, s);
        n_vec++;
        if (!s || p !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
            n_err++; $display("FAIL ones_p: got %h (seen=%0d), want fffffffffffffffe0000000000000001", p, s);
        end
        n_vec++;
        if (cap_a[2] !== 34'h1_FFFF_FFFE || cap_b[2] !== 34'h1_FFFF_FFFE) begin
            n_err++; $display("FAIL ones_issue2_ops: got a=%h b=%h, want 1fffffffe", cap_a[2], cap_b[2]);
        end
        n_vec++;
        if (cap_a[0] !== 34'h0_FFFF_FFFF || cap_a[1] !== 34'h0_FFFF_FFFF) begin
            n_err++; $display("FAIL ones_halves: got a0=%h a1=%h, want 0ffffffff", cap_a[0], cap_a[1]);
        end
    endtask

    task automatic test_var_latency;
        logic [127:0] p; logic e; int l; bit s;
        lat = '{1, 4, 9}; idx = 0; n_starts = 0;
        run_op(0, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, p, e, l, s);
        n_vec++;
        if (!s || l != 18) begin n_err++; $display("FAIL varlat_latency: got %0d (seen=%0d), want 18", l, s); end
        n_vec++;
        if (p !== 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000) begin
            n_err++; $display("FAIL varlat_p: got %h, want ffffffff00000000", p);
        end
        n_vec++;
        if (cap_a[0] !== 34'd0 || cap_a[1] !== 34'd1 || cap_b[1] !== 34'd0 || cap_b[2] !== 34'h0_FFFF_FFFF) begin
            n_err++; $display("FAIL varlat_ops: got a0=%h a1=%h b1=%h b2=%h, want 0 1 0 ffffffff",
                              cap_a[0], cap_a[1], cap_b[1], cap_b[2]);
        end
    endtask

    task automatic test_vectors;
        logic [63:0]  ta[4];
        logic [63:0]  tb_[4];
        logic [127:0] tp[4];
        logic [127:0] p; logic e; int l; bit s;
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb_[0] = 64'd1;
        tp[0] = 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF;
        ta[1] = 64'h8000_0000_0000_0000; tb_[1] = 64'd2;
        tp[1] = 128'h0000_0000_0000_0001_0000_0000_0000_0000;
        ta[2] = 64'h0000_0000_FFFF_FFFF; tb_[2] = 64'h0000_0000_FFFF_FFFF;
        tp[2] = 128'h0000_0000_0000_0000_FFFF_FFFE_0000_0001;
        ta[3] = 64'hFFFF_FFFF_0000_0000; tb_[3] = 64'hFFFF_FFFF_0000_0000;
        tp[3] = 128'hFFFF_FFFE_0000_0001_0000_0000_0000_0000;
        for (int i = 0; i < 4; i++) begin
            lat = '{2, 3, 1}; idx = 0; n_starts = 0;
            run_op(0, ta[i], tb_[i], p, e, l, s);
            n_vec++;
            if (!s || p !== tp[i] || e !== 1'b0 || l != 10) begin
                n_err++;
                $display("FAIL vec%0d: got P=%h err=%b lat=%0d seen=%0d, want P=%h err=0 lat=10",
                         i, p, e, l, s, tp[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int e0, e1;
        bit seen;
        lat = '{1, 1, 1}; idx = 0; n_starts = 0;
        @(negedge clk);
        bus.A = 64'h0000_0002_0000_0003; bus.B = 64'd5; bus.start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        bus.A = 64'h0000_0001_0000_0001; bus.B = 64'h0000_0001_0000_0001;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.valid_out === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        n_vec++;
        if (!seen || (cyc - e0) != 7 || bus.P !== 128'h0000_0000_0000_0000_0000_000A_0000_000F || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_first: got P=%h lat=%0d busy=%b seen=%0d, want P=a0000000f lat=7 busy=0",
                     bus.P, cyc - e0, bus.busy, seen);
        end
        @(negedge clk);
        bus.start = 1'b0;
        e1 = cyc;
        n_vec++;
        if (bus.busy !== 1'b1 || bus.sm_a !== 34'd1 || bus.sm_start !== 1'b1 || bus.valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%b sm_a=%h sm_start=%b vo=%b, want 1 1 1 0",
                     bus.busy, bus.sm_a, bus.sm_start, bus.valid_out);
        end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.valid_out === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        n_vec++;
        if (!seen || (cyc - e1) != 7 || bus.P !== 128'h0000_0000_0000_0001_0000_0002_0000_0001) begin
            n_err++;
            $display("FAIL b2b_second: got P=%h lat=%0d seen=%0d, want P=10000000200000001 lat=7",
                     bus.P, cyc - e1, seen);
        end
        @(negedge clk);
        n_vec++;
        if (n_starts != 6 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL b2b_starts: got %0d starts busy=%b, want 6 starts busy=0", n_starts, bus.busy);
        end
    endtask

    task automatic test_timeout;
        logic [127:0] p; logic e; int l; bit s;
        int bad;
        lat_t = '{1, 1, 1}; idx_t = 0; n_starts_t = 0;
        run_op(1, 64'd3, 64'd7, p, e, l, s);
        n_vec++;
        if (!s || p !== 128'd21 || e !== 1'b0) begin
            n_err++; $display("FAIL to_pre: got P=%h err=%b seen=%0d, want P=15 err=0", p, e, s);
        end
        lat_t = '{1, 20, 1}; idx_t = 0; n_starts_t = 0;
        run_op(1, 64'h0000_0009_0000_0005, 64'h0000_0002_0000_0004, p, e, l, s);
        n_vec++;
        if (!s || l != 11) begin n_err++; $display("FAIL to_latency: got %0d (seen=%0d), want 11", l, s); end
        n_vec++;
        if (p !== 128'd0 || e !== 1'b1 || bus_t.busy !== 1'b0) begin
            n_err++; $display("FAIL to_abort: got P=%h err=%b busy=%b, want P=0 err=1 busy=0", p, e, bus_t.busy);
        end
        n_vec++;
        if (n_starts_t != 2) begin n_err++; $display("FAIL to_starts: got %0d, want 2", n_starts_t); end
        @(negedge clk);
        n_vec++;
        if (bus_t.valid_out !== 1'b0 || bus_t.err !== 1'b0) begin
            n_err++; $display("FAIL to_pulse: got vo=%b err=%b, want 0 0", bus_t.valid_out, bus_t.err);
        end
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus_t.valid_out !== 1'b0 || bus_t.busy !== 1'b0 || bus_t.sm_start !== 1'b0 || bus_t.P !== 128'd0)
                bad++;
        end
        n_vec++;
        if (bad != 0 || pend_t) begin
            n_err++; $display("FAIL to_stray: got %0d active cycles (pending=%0d), want 0", bad, pend_t);
        end
    endtask

    task automatic test_reset_mid;
        logic [127:0] p; logic e; int l; bit s;
        int bad;
        lat = '{1, 1, 6}; idx = 0; n_starts = 0;
        @(negedge clk);
        bus.A = 64'h1234_5678_9ABC_DEF0; bus.B = 64'h0FED_CBA9_8765_4321; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_vec++;
        if (bus.busy !== 1'b1 || n_starts != 3 || bus.P === 128'd0) begin
            n_err++; $display("FAIL rmid_pre: got busy=%b starts=%0d P=%h, want busy=1 starts=3 P!=0",
                              bus.busy, n_starts, bus.P);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.busy, bus.valid_out, bus.err, bus.sm_start, bus.sm_a, bus.sm_b, bus.P} !== '0) begin
            n_err++;
            $display("FAIL rmid_async: got busy=%b vo=%b err=%b sms=%b sma=%h smb=%h P=%h, want all 0",
                     bus.busy, bus.valid_out, bus.err, bus.sm_start, bus.sm_a, bus.sm_b, bus.P);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.valid_out !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        n_vec++;
        if (bad != 0) begin n_err++; $display("FAIL rmid_quiet: got %0d active cycles, want 0", bad); end
        lat = '{1, 1, 1}; idx = 0; n_starts = 0;
        run_op(0, 64'd6, 64'd7, p, e, l, s);
        n_vec++;
        if (!s || p !== 128'd42 || e !== 1'b0 || l != 7) begin
            n_err++; $display("FAIL rmid_after: got P=%h err=%b lat=%0d seen=%0d, want P=2a err=0 lat=7",
                              p, e, l, s);
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.sm_p = '0;
        bus_t.start = 1'b0; bus_t.A = '0; bus_t.B = '0; bus_t.sm_p = '0;
        lat = '{1, 1, 1};
        lat_t = '{1, 1, 1};
        test_reset();
        test_basic();
        test_all_ones();
        test_var_latency();
        test_vectors();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, want completion", $time);
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
